din_demux_wbuf: RTL and testbench

//  Write-side counterpart of the read-data cache/memory select path. Accepts processor writes,

---
 rtl/din_demux_pkg.sv | 20 ++
 rtl/din_demux_wbuf_fifo.sv | 61 ++++++
 rtl/din_demux_wbuf.sv | 118 +++++++++++
 tb/tb_din_demux_wbuf.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/din_demux_pkg.sv
// Shared definitions for the processor write path: FSM state encoding and
// write-buffer entry width.
package din_demux_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int unsigned DATA_WIDTH_DEF = 8;
  localparam int unsigned ADDR_WIDTH_DEF = 16;
  localparam int unsigned ENTRY_W        = ADDR_WIDTH_DEF + DATA_WIDTH_DEF;

  // Entry width for a given address/data configuration ({addr, data} packed).
  function automatic int unsigned entry_w(input int unsigned aw, input int unsigned dw);
    return aw + dw;
  endfunction

endpackage

// File: rtl/din_demux_wbuf_fifo.sv
// Synchronous write-buffer FIFO with a rewrite port for the most recently
// pushed (tail) entry, used for store coalescing.
module wbuf_fifo #(
  parameter int unsigned W     = 24,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       rewrite,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               head,
  output logic [W-1:0]               tail_entry,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW-1:0] last_idx;
  logic          do_push;
  logic          do_pop;

  assign full       = (count == CW'(DEPTH));
  assign empty      = (count == '0);
  assign do_push    = push && !full;
  assign do_pop     = pop && !empty;
  assign last_idx   = wptr - AW'(1);
  assign head       = mem[rptr];
  assign tail_entry = mem[last_idx];

  // Storage, pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[AW'(i)] <= '0;
    end else begin
      if (do_push) begin
        mem[wptr] <= din;
        wptr      <= wptr + AW'(1);
      end else if (rewrite && !empty) begin
        mem[last_idx] <= din;
      end
      if (do_pop) rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/din_demux_wbuf.sv
// Processor write path: updates the cache on a hit and posts every write
// through a write buffer to memory; flush drains the buffer.
// Optional feature: WBUF_COALESCE_EN merges a write into the tail entry when
// it targets the same address.
module din_demux_wbuf
  import din_demux_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  cache_hit,
  output logic                  wr_ready,
  output logic                  cache_we,
  output logic [ADDR_WIDTH-1:0] cache_addr,
  output logic [DATA_WIDTH-1:0] cache_data,
  output logic                  mem_wr_valid,
  input  logic                  mem_wr_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  input  logic                  flush_req,
  output logic                  flush_done,
  output logic                  buf_full,
  output logic                  buf_empty
);

  localparam int unsigned EW = entry_w(ADDR_WIDTH, DATA_WIDTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  state_t          state;
  state_t          state_nxt;
  logic            full;
  logic            empty;
  logic            accept;
  logic            pop;
  logic            push;
  logic            coalesce;
  logic [EW-1:0]   head;
  logic [EW-1:0]   tail_entry;
  logic [CW-1:0]   count;

  assign wr_ready     = (state == IDLE) && !full;
  assign accept       = wr_req && wr_ready;
  assign mem_wr_valid = !empty;
  assign pop          = mem_wr_valid && mem_wr_ready;
  assign {mem_addr, mem_data} = head;
  assign buf_full     = full;
  assign buf_empty    = empty;
  assign flush_done   = (state == DONE);

`ifdef WBUF_COALESCE_EN
  // The tail may only be merged into when it is not also the head leaving now.
  assign coalesce = accept && !empty &&
                    (tail_entry[EW-1:DATA_WIDTH] == wr_addr) &&
                    !((count == CW'(1)) && pop);
`else
  logic unused_tail;
  assign unused_tail = ^{tail_entry, count};
  assign coalesce    = 1'b0;
`endif

  assign push = accept && !coalesce;

  wbuf_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .pop        (pop),
    .rewrite    (coalesce),
    .din        ({wr_addr, wr_data}),
    .head       (head),
    .tail_entry (tail_entry),
    .full       (full),
    .empty      (empty),
    .count      (count)
  );

  // Flush FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Flush FSM next state: drain until empty, then one-cycle DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (flush_req) state_nxt = DRAIN;
      DRAIN:   if (empty)     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Cache write strobe: one cycle after an accepted hit, with registered addr/data.
  always_ff @(posedge clk) begin
    if (rst) begin
      cache_we   <= 1'b0;
      cache_addr <= '0;
      cache_data <= '0;
    end else begin
      cache_we <= accept && cache_hit;
      if (accept && cache_hit) begin
        cache_addr <= wr_addr;
        cache_data <= wr_data;
      end
    end
  end

endmodule

// File: tb/tb_din_demux_wbuf.sv
// Self-checking bench for din_demux_wbuf: scoreboard of expected memory
// writes plus a reference model of occupancy, cache strobe and flush FSM.
module tb_din_demux_wbuf;

  localparam int DW    = 8;
  localparam int AW    = 16;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          cache_hit;
  logic          wr_ready;
  logic          cache_we;
  logic [AW-1:0] cache_addr;
  logic [DW-1:0] cache_data;
  logic          mem_wr_valid;
  logic          mem_wr_ready;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          flush_req;
  logic          flush_done;
  logic          buf_full;
  logic          buf_empty;

  always #5 clk = ~clk;

  din_demux_wbuf #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .DEPTH      (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_req       (wr_req),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .cache_hit    (cache_hit),
    .wr_ready     (wr_ready),
    .cache_we     (cache_we),
    .cache_addr   (cache_addr),
    .cache_data   (cache_data),
    .mem_wr_valid (mem_wr_valid),
    .mem_wr_ready (mem_wr_ready),
    .mem_addr     (mem_addr),
    .mem_data     (mem_data),
    .flush_req    (flush_req),
    .flush_done   (flush_done),
    .buf_full     (buf_full),
    .buf_empty    (buf_empty)
  );

  int checks = 0;
  int passes = 0;

  // Model state: expected buffer contents, flush state (0 idle,1 drain,2 done), cache strobe.
  logic [AW+DW-1:0] q[$];
  int               mst = 0;
  logic             exp_cwe = 1'b0;
  logic [AW-1:0]    exp_ca = '0;
  logic [DW-1:0]    exp_cd = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // One clock: compare outputs against the model, advance the model, step the clock.
  task automatic cycle();
    int               sz;
    bit               acc;
    bit               pop_now;
    bit               coal;
    logic [AW+DW-1:0] ent;
    @(negedge clk);
    sz = q.size();
    check("cache_we",     cache_we,     exp_cwe);
    check("cache_addr",   cache_addr,   exp_ca);
    check("cache_data",   cache_data,   exp_cd);
    check("buf_empty",    buf_empty,    sz == 0);
    check("buf_full",     buf_full,     sz == DEPTH);
    check("mem_wr_valid", mem_wr_valid, sz != 0);
    check("wr_ready",     wr_ready,     (mst == 0) && (sz < DEPTH));
    check("flush_done",   flush_done,   mst == 2);
    if (rst) begin
      q.delete();
      mst     = 0;
      exp_cwe = 1'b0;
      exp_ca  = '0;
      exp_cd  = '0;
    end else begin
      acc     = wr_req && (mst == 0) && (sz < DEPTH);
      pop_now = mem_wr_ready && (sz != 0);
      coal    = 1'b0;
`ifdef WBUF_COALESCE_EN
      if (acc && sz > 0) begin
        ent = q[sz-1];
        if (ent[AW+DW-1:DW] == wr_addr && !(sz == 1 && pop_now)) coal = 1'b1;
      end
`endif
      if (pop_now) begin
        ent = q.pop_front();
        check("mem_addr", mem_addr, ent[AW+DW-1:DW]);
        check("mem_data", mem_data, ent[DW-1:0]);
      end
      if (coal)     q[q.size()-1] = {wr_addr, wr_data};
      else if (acc) q.push_back({wr_addr, wr_data});
      exp_cwe = acc && cache_hit;
      if (acc && cache_hit) begin
        exp_ca = wr_addr;
        exp_cd = wr_data;
      end
      case (mst)
        0:       if (flush_req) mst = 1;
        1:       if (sz == 0)   mst = 2;
        default: mst = 0;
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic hit);
    wr_req    = 1'b1;
    wr_addr   = a;
    wr_data   = d;
    cache_hit = hit;
    cycle();
    wr_req    = 1'b0;
    cache_hit = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    int lat;
    rst = 1'b1; wr_req = 1'b0; wr_addr = '0; wr_data = '0; cache_hit = 1'b0;
    mem_wr_ready = 1'b0; flush_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // 1: reset values, single hit write, cache strobe and memory post
    check("rst_buf_empty",  buf_empty,    1'b1);
    check("rst_buf_full",   buf_full,     1'b0);
    check("rst_cache_we",   cache_we,     1'b0);
    check("rst_mem_valid",  mem_wr_valid, 1'b0);
    check("rst_flush_done", flush_done,   1'b0);
    check("rst_cache_addr", cache_addr,   32'h0);
    check("rst_wr_ready",   wr_ready,     1'b1);
    write(16'h0010, 8'h5A, 1'b1);
    check("t1_cache_we",  cache_we,     1'b1);
    check("t1_cache_a",   cache_addr,   32'h0010);
    check("t1_mem_valid", mem_wr_valid, 1'b1);
    check("t1_mem_data",  mem_data,     32'h5A);
    mem_wr_ready = 1'b1;
    cycle();
    mem_wr_ready = 1'b0;
    check("t1_empty", buf_empty, 1'b1);

    // 2/3: fill, held 5th write, pop while full refuses push, then 5th accepted
    for (int i = 1; i <= 4; i++) write(16'h0100 + 16'(i), 8'(i), 1'b0);
    check("t2_full",     buf_full, 1'b1);
    check("t2_no_ready", wr_ready, 1'b0);
    wr_req = 1'b1; wr_addr = 16'h0105; wr_data = 8'h05;
    cycle();
    mem_wr_ready = 1'b1;
    cycle();
    mem_wr_ready = 1'b0;
    check("t3_not_full", buf_full, 1'b0);
    check("t3_reenable", wr_ready, 1'b1);
    cycle();
    wr_req = 1'b0;
    check("t2_full_again", buf_full, 1'b1);
    mem_wr_ready = 1'b1;
    repeat (6) cycle();
    mem_wr_ready = 1'b0;
    check("t2_drained", buf_empty, 1'b1);

    // 4: flush with three buffered writes plus one accepted in the flush cycle
    for (int i = 0; i < 3; i++) write(16'h0200 + 16'(i), 8'hA0 + 8'(i), 1'b1);
    flush_req = 1'b1; mem_wr_ready = 1'b1;
    wr_req = 1'b1; wr_addr = 16'h0300; wr_data = 8'hC3; cache_hit = 1'b0;
    cycle();
    flush_req = 1'b0;
    check("t4_drain_no_ready", wr_ready, 1'b0);
    pulses = 0;
    for (int k = 0; k < 20 && pulses == 0; k++) begin
      cycle();
      if (flush_done) pulses++;
    end
    wr_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cycle();
      if (flush_done) pulses++;
    end
    check("t4_flush_pulses", pulses, 1);
    mem_wr_ready = 1'b0;

    // 4b: flush on empty buffer, pulse two cycles after request
    flush_req = 1'b1;
    cycle();
    flush_req = 1'b0;
    lat = 1;
    while (!flush_done && lat < 10) begin
      cycle();
      lat++;
    end
    check("t4_empty_flush_lat", lat, 2);
    repeat (2) cycle();

    // 5: same-address writes while memory stalls
    write(16'h0020, 8'h11, 1'b0);
    write(16'h0020, 8'h22, 1'b0);
`ifdef WBUF_COALESCE_EN
    check("t5_head_data", mem_data, 32'h22);
`else
    check("t5_head_data", mem_data, 32'h11);
`endif
    mem_wr_ready = 1'b1;
    repeat (3) cycle();
    mem_wr_ready = 1'b0;
    check("t5_drained", buf_empty, 1'b1);

    // 6: reset in the middle of a stalled drain
    write(16'h0400, 8'h44, 1'b1);
    write(16'h0401, 8'h45, 1'b0);
    flush_req = 1'b1;
    cycle();
    flush_req = 1'b0;
    repeat (2) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("t6_empty",      buf_empty,    1'b1);
    check("t6_mem_valid",  mem_wr_valid, 1'b0);
    check("t6_flush_done", flush_done,   1'b0);
    check("t6_cache_data", cache_data,   32'h0);
    check("t6_wr_ready",   wr_ready,     1'b1);
    repeat (3) cycle();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
